fp16_round_pack: RTL and testbench

- Sequential round-and-pack back end for half-precision results; the encode-side counterpart of operand unpacking.
- Accepts an unrounded sum (sign, biased unbounded exponent, normalized 24-bit significand, sticky) plus special-case indications.
- Produces a packed IEEE-754 binary16 word and {NV,OF,UF,NX} flags through a 2-stage valid/ready pipeline.
- Sits between the fma16 datapath normalizer and the result register / writeback.

---
 rtl/fp16_pkg.sv | 51 +++++
 rtl/fp16_round_pack_if.sv | 45 ++++
 rtl/fp16_round_decide.sv | 41 ++++
 rtl/fp16_round_pack.sv | 160 ++++++++++++++++
 tb/tb_fp16_round_pack.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/fp16_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp16_pkg
// Description : Shared constants, rounding-mode encoding, flag bit positions
//               and the stage-1 pipeline record for the binary16 round/pack
//               back end.
// Revision    : 1.0 - initial release
// ============================================================================
package fp16_pkg;

  localparam int          BIAS    = 15;
  localparam logic [14:0] MAXNORM = 15'h7BFF;
  localparam logic [14:0] INF     = 15'h7C00;
  localparam logic [15:0] QNAN    = 16'h7E00;

  typedef enum logic [1:0] {
    RZ  = 2'b00,
    RNE = 2'b01,
    RM  = 2'b10,
    RP  = 2'b11
  } roundmode_t;

  // Bit positions inside the {NV,OF,UF,NX} flag vector
  localparam int NV = 3;
  localparam int OF = 2;
  localparam int UF = 1;
  localparam int NX = 0;

  // Kept mantissa width (hidden bit + 10 fraction bits) and the width of the
  // pre-decremented exponent carried between stages
  localparam int MANT_W = 11;
  localparam int EXP_W  = 8;

  // Everything stage 2 needs: the rounding decision is already made, only
  // the increment, overflow resolution and packing remain
  typedef struct packed {
    logic              sign;
    roundmode_t        mode;
    logic [MANT_W-1:0] mant;
    logic [EXP_W-1:0]  exp_base;   // Se-1 for normals, 0 for subnormals
    logic              inc;
    logic              inexact;    // G|S before rounding
    logic              tiny;
    logic              nv;
    logic              special;
    logic [15:0]       spec_res;
    logic [3:0]        spec_flags;
  } s1_t;

endpackage
`default_nettype wire

// File: rtl/fp16_round_pack_if.sv
`default_nettype none
// ============================================================================
// Module      : fp16_round_pack_if
// Description : Input beat and output result handshake bundle for the
//               binary16 round/pack back end.
// Revision    : 1.0 - initial release
// ============================================================================
interface fp16_round_pack_if
  import fp16_pkg::*;
#(
  parameter int MW = 24,
  parameter int EW = 8
);

  logic          in_valid;
  logic          in_ready;
  logic          Ss;
  logic [EW-1:0] Se;
  logic [MW-1:0] Sm;
  logic          sticky;
  logic          nan_in;
  logic          inf_in;
  logic          nv_in;
  roundmode_t    roundmode;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   result;
  logic [3:0]    flags;

  // Producer of beats / consumer of results
  modport master (
    output in_valid, Ss, Se, Sm, sticky, nan_in, inf_in, nv_in, roundmode,
    output out_ready,
    input  in_ready, out_valid, result, flags
  );

  // The round/pack block itself
  modport slave (
    input  in_valid, Ss, Se, Sm, sticky, nan_in, inf_in, nv_in, roundmode,
    input  out_ready,
    output in_ready, out_valid, result, flags
  );

endinterface
`default_nettype wire

// File: rtl/fp16_round_decide.sv
`default_nettype none
// ============================================================================
// Module      : fp16_round_decide
// Description : Combinational L/G/S extraction and round-up decision for a
//               binary16 target, given the aligned significand tail.
// Revision    : 1.0 - initial release
// ============================================================================
module fp16_round_decide
  import fp16_pkg::*;
#(
  parameter int MW = 24
)
(
  input  logic           sign,
  input  roundmode_t     mode,
  input  logic [MW-11:0] tail,        // significand from L down to bit 0
  input  logic           sticky_in,
  output logic           guard,
  output logic           sticky_out,
  output logic           inc
);

  logic lsb;

  // Pick L/G/S out of the tail and decide whether the kept mantissa rounds up
  always_comb begin
    lsb        = tail[MW-11];
    guard      = tail[MW-12];
    sticky_out = (|tail[MW-13:0]) | sticky_in;
    inc        = 1'b0;
    case (mode)
      RZ:      inc = 1'b0;
      RNE:     inc = guard & (sticky_out | lsb);
      RM:      inc = sign & (guard | sticky_out);
      RP:      inc = ~sign & (guard | sticky_out);
      default: inc = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/fp16_round_pack.sv
`default_nettype none
// ============================================================================
// Module      : fp16_round_pack
// Description : Two-stage valid/ready round-and-pack of an unrounded
//               significand/exponent pair into IEEE-754 binary16 with
//               {NV,OF,UF,NX} flags.
// Revision    : 1.0 - initial release
// ============================================================================
module fp16_round_pack
  import fp16_pkg::*;
#(
  parameter int MW = 24,
  parameter int EW = 8
)
(
  input logic               clk,
  input logic               reset,
  fp16_round_pack_if.slave  bus
);

  localparam int          SAT     = MW + 1;           // shift that clears Sm
  localparam int          SHAMT_W = $clog2(SAT + 1);
  localparam logic [19:0] OVF_AT  = 20'((2 * BIAS + 1) * 1024);

  logic                 tiny;
  logic signed [EW+1:0] amt;
  logic [SHAMT_W-1:0]   shamt;
  logic [2*MW:0]        ext;
  logic [MW-1:0]        sh_sig;
  logic                 shout;
  logic                 guard;
  logic                 sticky_all;
  logic                 inc;
  s1_t                  s1_next;
  s1_t                  s1_q;
  logic                 s1_valid;
  logic                 s2_take;
  logic                 in_ready;
  logic [19:0]          sum;
  logic                 use_inf;
  logic [15:0]          res_next;
  logic [3:0]           flags_next;
  logic                 out_valid_q;
  logic [15:0]          result_q;
  logic [3:0]           flags_q;

  // Denormalizing right shift for Se<=0; saturation stops wrap for huge |Se|
  always_comb begin
    tiny  = bus.Se[EW-1] | (bus.Se == '0);
    amt   = (EW+2)'(1) - $signed({{2{bus.Se[EW-1]}}, bus.Se});
    shamt = '0;
    if (tiny) begin
      if (amt > (EW+2)'(SAT)) shamt = SHAMT_W'(SAT);
      else                    shamt = amt[SHAMT_W-1:0];
    end
    ext    = {bus.Sm, {(MW+1){1'b0}}} >> shamt;
    sh_sig = ext[2*MW:MW+1];
    shout  = |ext[MW:0];
  end

  fp16_round_decide #(.MW(MW)) u_decide (
    .sign       (bus.Ss),
    .mode       (bus.roundmode),
    .tail       (sh_sig[MW-11:0]),
    .sticky_in  (bus.sticky | shout),
    .guard      (guard),
    .sticky_out (sticky_all),
    .inc        (inc)
  );

  // Build the stage-1 record; specials are resolved here with their priority
  always_comb begin
    s1_next            = '0;
    s1_next.sign       = bus.Ss;
    s1_next.mode       = bus.roundmode;
    s1_next.mant       = sh_sig[MW-1:MW-11];
    s1_next.exp_base   = tiny ? '0 : EXP_W'(bus.Se - EW'(1));
    s1_next.inc        = inc;
    s1_next.inexact    = guard | sticky_all;
    s1_next.tiny       = tiny;
    s1_next.nv         = bus.nv_in;
    if (bus.nan_in) begin
      s1_next.special    = 1'b1;
      s1_next.spec_res   = QNAN;
      s1_next.spec_flags = {bus.nv_in, 3'b000};
    end else if (bus.inf_in) begin
      s1_next.special    = 1'b1;
      s1_next.spec_res   = {bus.Ss, INF};
      s1_next.spec_flags = {bus.nv_in, 3'b000};
    end else if (bus.Sm == '0) begin
      s1_next.special    = 1'b1;
      s1_next.spec_res   = {bus.Ss, 15'h0000};
      s1_next.spec_flags = 4'b0000;
    end
  end

  // Increment and pack: the hidden bit carries into the exponent field, so a
  // mantissa carry-out or a subnormal rounding up to 0x400 renormalizes itself
  always_comb begin
    sum = {2'b00, s1_q.exp_base, 10'b0} + {9'b0, s1_q.mant} + {19'b0, s1_q.inc};
    case (s1_q.mode)
      RZ:      use_inf = 1'b0;
      RNE:     use_inf = 1'b1;
      RM:      use_inf = s1_q.sign;
      RP:      use_inf = ~s1_q.sign;
      default: use_inf = 1'b1;
    endcase
    flags_next = '0;
    if (s1_q.special) begin
      res_next   = s1_q.spec_res;
      flags_next = s1_q.spec_flags;
    end else if (sum >= OVF_AT) begin
      res_next       = use_inf ? {s1_q.sign, INF} : {s1_q.sign, MAXNORM};
      flags_next[NV] = s1_q.nv;
      flags_next[OF] = 1'b1;
      flags_next[NX] = 1'b1;
    end else begin
      res_next       = {s1_q.sign, sum[14:0]};
      flags_next[NV] = s1_q.nv;
      flags_next[UF] = s1_q.tiny & s1_q.inexact;
      flags_next[NX] = s1_q.inexact;
    end
  end

  assign s2_take  = ~out_valid_q | bus.out_ready;
  assign in_ready = ~s1_valid | (s1_valid & s2_take);

  // Stage 1 register: loads whenever the slot is free or moving on
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (in_ready) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) s1_q <= s1_next;
    end
  end

  // Output register: holds steady while the consumer stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      result_q    <= 16'h0000;
      flags_q     <= 4'b0000;
    end else if (s2_take) begin
      out_valid_q <= s1_valid;
      if (s1_valid) begin
        result_q <= res_next;
        flags_q  <= flags_next;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_fp16_round_pack.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp16_round_pack
// Description : Directed-vector scoreboard bench for fp16_round_pack.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp16_round_pack;
  import fp16_pkg::*;

  typedef struct packed {
    logic [7:0]  id;
    logic [15:0] res;
    logic [3:0]  fl;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t q[$];

  fp16_round_pack_if #(.MW(24), .EW(8)) bus ();

  fp16_round_pack #(.MW(24), .EW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Issue one beat at posedge+1; wait (bounded) for acceptance, then push.
  task automatic send(input logic ss, input logic [7:0] se, input logic [23:0] sm,
                      input logic st, input logic nan, input logic inf,
                      input logic nv, input logic [1:0] mode,
                      input logic [15:0] er, input logic [3:0] ef,
                      input logic [7:0] id);
    int   tmo;
    exp_t e;
    bus.in_valid  = 1'b1;
    bus.Ss        = ss;
    bus.Se        = se;
    bus.Sm        = sm;
    bus.sticky    = st;
    bus.nan_in    = nan;
    bus.inf_in    = inf;
    bus.nv_in     = nv;
    bus.roundmode = roundmode_t'(mode);
    tmo = 0;
    @(negedge clk);
    while (!bus.in_ready && tmo < 50) begin
      tmo++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout beat%0d: actual=in_ready_low required=accept", id);
    end else begin
      e.id  = id;
      e.res = er;
      e.fl  = ef;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int tmo;
    tmo = 0;
    while (q.size() != 0 && tmo < 200) begin
      tmo++;
      @(posedge clk);
    end
    chk("drain_queue_empty", q.size(), 0);
    #1;
  endtask

  // Monitor: compare head of scoreboard whenever a result is presented
  always @(negedge clk) begin
    if (bus.out_valid) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: actual=%0h/%0b required=none", bus.result, bus.flags);
      end else begin
        chk($sformatf("beat%0d_result", q[0].id), 32'(bus.result), 32'(q[0].res));
        chk($sformatf("beat%0d_flags", q[0].id), 32'(bus.flags), 32'(q[0].fl));
        if (bus.out_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.Ss        = 1'b0;
    bus.Se        = '0;
    bus.Sm        = '0;
    bus.sticky    = 1'b0;
    bus.nan_in    = 1'b0;
    bus.inf_in    = 1'b0;
    bus.nv_in     = 1'b0;
    bus.roundmode = RNE;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk("reset_out_valid", 32'(bus.out_valid), 0);
    chk("reset_result", 32'(bus.result), 32'h0000);
    chk("reset_flags", 32'(bus.flags), 0);
    chk("reset_in_ready", 32'(bus.in_ready), 1);
    @(posedge clk);
    #1;

    // Latency: presented in cycle P, result visible in cycle P+2
    send(0, 8'd15, 24'h800000, 0, 0, 0, 0, 2'b01, 16'h3C00, 4'b0000, 1);
    @(negedge clk);
    chk("latency_cycle1_out_valid", 32'(bus.out_valid), 0);
    @(negedge clk);
    chk("latency_cycle2_out_valid", 32'(bus.out_valid), 1);
    wait_drain();

    // Directed vectors, streamed back to back
    send(0, 8'd15,  24'h801000, 0, 0, 0, 0, 2'b01, 16'h3C00, 4'b0001, 2);
    send(0, 8'd15,  24'h803000, 0, 0, 0, 0, 2'b01, 16'h3C02, 4'b0001, 3);
    send(0, 8'd15,  24'h803000, 0, 0, 0, 0, 2'b00, 16'h3C01, 4'b0001, 4);
    send(0, 8'd31,  24'h800000, 0, 0, 0, 0, 2'b01, 16'h7C00, 4'b0101, 5);
    send(0, 8'd31,  24'h800000, 0, 0, 0, 0, 2'b00, 16'h7BFF, 4'b0101, 6);
    send(1, 8'd31,  24'h800000, 0, 0, 0, 0, 2'b11, 16'hFBFF, 4'b0101, 7);
    send(1, 8'd31,  24'h800000, 0, 0, 0, 0, 2'b10, 16'hFC00, 4'b0101, 8);
    send(0, 8'd0,   24'h800000, 0, 0, 0, 0, 2'b01, 16'h0200, 4'b0000, 9);
    send(0, 8'hF6,  24'h800000, 0, 0, 0, 0, 2'b01, 16'h0000, 4'b0011, 10);
    send(0, 8'hF6,  24'h800000, 0, 0, 0, 0, 2'b11, 16'h0001, 4'b0011, 11);
    send(0, 8'd0,   24'hFFFFFF, 0, 0, 0, 0, 2'b01, 16'h0400, 4'b0011, 12);
    send(0, 8'd15,  24'h800000, 0, 1, 0, 1, 2'b01, 16'h7E00, 4'b1000, 13);
    send(1, 8'd15,  24'h800000, 0, 0, 1, 0, 2'b01, 16'hFC00, 4'b0000, 14);
    send(0, 8'h80,  24'h800000, 0, 0, 0, 0, 2'b11, 16'h0001, 4'b0011, 15);
    send(1, 8'd15,  24'h000000, 0, 0, 0, 0, 2'b01, 16'h8000, 4'b0000, 16);
    send(0, 8'd15,  24'hFFFFFF, 0, 0, 0, 0, 2'b01, 16'h4000, 4'b0001, 17);
    wait_drain();

    // Backpressure: consumer stalls, pipe fills after two beats
    bus.out_ready = 1'b0;
    send(0, 8'd15,  24'h800000, 0, 0, 0, 0, 2'b01, 16'h3C00, 4'b0000, 20);
    send(0, 8'd15,  24'h803000, 0, 0, 0, 0, 2'b01, 16'h3C02, 4'b0001, 21);
    @(negedge clk);
    chk("stall_in_ready_low", 32'(bus.in_ready), 0);
    @(posedge clk);
    #1;
    fork
      begin
        send(0, 8'd31, 24'h800000, 0, 0, 0, 0, 2'b01, 16'h7C00, 4'b0101, 22);
        send(0, 8'd0,  24'h800000, 0, 0, 0, 0, 2'b01, 16'h0200, 4'b0000, 23);
      end
      begin
        repeat (2) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    wait_drain();

    // Reset with two beats in flight
    bus.out_ready = 1'b0;
    send(0, 8'd15,  24'h801000, 0, 0, 0, 0, 2'b01, 16'h3C00, 4'b0001, 30);
    send(0, 8'd15,  24'h803000, 0, 0, 0, 0, 2'b00, 16'h3C01, 4'b0001, 31);
    reset = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    @(negedge clk);
    chk("flush_out_valid", 32'(bus.out_valid), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk("flush_no_emission", seen, 0);
    chk("flush_in_ready", 32'(bus.in_ready), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
